hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//  Downstream consumer of the multicycle multiplier in the EX stage. Issues the
//  one-cycle Multu start and counts the fixed multiply latency. Captures the
//  64-bit product into the HI/LO architectural registers. Stalls the pipeline
//  on any HI/LO access (MFHI/MFLO/MTHI/MTLO, new MULTU) while a multiply is in flight.
// PARAMETERS
//  MULT_LATENCY  34  edges from the edge sampling mult_start to the edge at which mult_product is valid
//  CNT_W         6   counter width; must satisfy 2**CNT_W > MULT_LATENCY
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-low (0 = reset asserted)
//  mult_start    in   1   EX holds a MULTU; held by upstream until accepted
//  flush         in   1   EX instruction squashed (branch/exception); abort multiply
//  mfhi          in   1   EX holds MFHI
//  mflo          in   1   EX holds MFLO
//  mthi          in   1   EX holds MTHI
//  mtlo          in   1   EX holds MTLO
//  wr_data       in   32  rs value for MTHI/MTLO
//  mult_product  in   64  multiplier dataOut
//  multu_out     out  1   to multiplier Multu; = mult_start & (state==IDLE) & ~flush, combinational
//  stall         out  1   freeze IF/ID/EX; combinational
//  rd_data       out  32  MFHI/MFLO result, combinational
//  hi            out  32  HI register
//  lo            out  32  LO register
//  busy          out  1   1 while state==BUSY
//  done          out  1   registered, one-cycle pulse on the edge after capture
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, cnt=0, hi=0, lo=0, done=0. Hence stall=0, busy=0, multu_out=0.
//  Reset mid-multiply discards the operation; the multiplier has its own reset.
//  States: IDLE, BUSY (2-state FSM).
//  IDLE: mult_start & ~flush -> BUSY, cnt<=MULT_LATENCY-1, multu_out=1 that cycle.
//  Start is accepted in one cycle; stall=0 that cycle.
//  BUSY: cnt decrements each edge.
//   At cnt==0 & ~flush: hi<=mult_product[63:32], lo<=mult_product[31:0], state<=IDLE, done<=1 next cycle.
//   flush in BUSY (any cnt, including 0): state<=IDLE, no capture, done stays 0.
//  Latency: HI/LO update MULT_LATENCY edges after the accepting edge.
//   A dependent MFHI/MFLO reads the new value on the first cycle it is not stalled.
//  stall = busy & (mult_start|mfhi|mflo|mthi|mtlo) & ~flush. flush never stalls.
//   A mult_start during BUSY is not accepted and is not forwarded: multu_out=0.
//  MTHI/MTLO in IDLE, ~flush: hi (resp. lo) <= wr_data on the edge.
//   Both asserted together: both registers written.
//   If mult_start is also asserted, the MT write is ignored (decoder never does this).
//  rd_data = mfhi ? hi : mflo ? lo : 32'b0. mfhi wins if both are asserted.
//   No bypass; register contents only.
//  The product is unsigned 64-bit and is captured verbatim, with no sign/width manipulation.
//  The counter never wraps: it is reloaded only from IDLE and holds 0 in IDLE.
// STRUCTURE
//  Shared package mips_pkg:
//   - HILO FSM encoding (IDLE=1'b0, BUSY=1'b1)
//   - MULT_LATENCY default
//   - WORD_W=32, DWORD_W=64
//  One sub-module, hilo_regs: the HI/LO flops with their write enables and async reset.
//  The FSM, counter and stall logic stay in hilo_unit.
// TESTING
//  1. Reset: reset=0 with random inputs -> hi=lo=0, stall=busy=done=multu_out=0.
//     Release reset -> state holds.
//  2. Multiply with a real multiplier attached:
//     mult_start with A=32'hFFFF_FFFF, B=32'h2 -> multu_out pulse 1 cycle, busy for 34 cycles,
//     then hi=32'h1, lo=32'hFFFF_FFFE, done pulse 1 cycle.
//  3. MFLO issued 3 cycles after MULTU (A=7, B=6) -> stall=1 until capture,
//     then rd_data=32'd42 on the first unstalled cycle.
//  4. flush at cnt==0 during BUSY -> no HI/LO change (prior hi=32'hA5A5_A5A5 kept), done=0, state IDLE.
//  5. In IDLE, mthi & mtlo both asserted with wr_data=32'h1234_5678 -> hi=lo=32'h1234_5678.
//     Then mfhi&mflo -> rd_data=hi.
//  6. Second mult_start while BUSY -> stall=1, multu_out=0.
//     The start is accepted the cycle after capture, with a new 34-cycle window.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO unit.
// Contents: data widths, default multiplier latency and the HI/LO FSM encoding.
package mips_pkg;

    localparam int WORD_W           = 32;
    localparam int DWORD_W          = 64;
    localparam int MULT_LATENCY_DEF = 34;

    // HI/LO FSM state encoding
    localparam logic [0:0] HILO_IDLE = 1'b0;
    localparam logic [0:0] HILO_BUSY = 1'b1;

endpackage

// File: rtl/hilo_if.sv
// EX-stage <-> HI/LO unit bundle.
// master: EX decode / multiplier side (drives requests and the product).
// slave : hilo_unit (drives Multu start, stall, read data, HI/LO, status).
interface hilo_if;
    import mips_pkg::*;

    logic                 mult_start;
    logic                 flush;
    logic                 mfhi;
    logic                 mflo;
    logic                 mthi;
    logic                 mtlo;
    logic [WORD_W-1:0]    wr_data;
    logic [DWORD_W-1:0]   mult_product;
    logic                 multu_out;
    logic                 stall;
    logic [WORD_W-1:0]    rd_data;
    logic [WORD_W-1:0]    hi;
    logic [WORD_W-1:0]    lo;
    logic                 busy;
    logic                 done;

    modport master (
        output mult_start, flush, mfhi, mflo, mthi, mtlo, wr_data, mult_product,
        input  multu_out, stall, rd_data, hi, lo, busy, done
    );

    modport slave (
        input  mult_start, flush, mfhi, mflo, mthi, mtlo, wr_data, mult_product,
        output multu_out, stall, rd_data, hi, lo, busy, done
    );

endinterface

// File: rtl/hilo_unit_regs.sv
// HI/LO architectural registers.
// Ports: clk, reset (async active-low), hi_we/lo_we write enables,
//        hi_wdata/lo_wdata write data, hi/lo register contents.
module hilo_regs
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [WORD_W-1:0] hi_wdata,
    input  logic [WORD_W-1:0] lo_wdata,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    logic [WORD_W-1:0] hi_q;
    logic [WORD_W-1:0] hi_d;
    logic [WORD_W-1:0] lo_q;
    logic [WORD_W-1:0] lo_d;

    // Next-state selection for HI and LO
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we) begin
            hi_d = hi_wdata;
        end else begin
            hi_d = hi_q;
        end
        if (lo_we) begin
            lo_d = lo_wdata;
        end else begin
            lo_d = lo_q;
        end
    end

    // HI/LO storage with async reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= {WORD_W{1'b0}};
            lo_q <= {WORD_W{1'b0}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: issues the Multu start, counts the fixed multiplier latency,
// captures the 64-bit product into HI/LO and stalls EX on HI/LO accesses
// while a multiply is in flight.
// Ports: clk, reset (async active-low), bus (hilo_if.slave: requests,
//        product, multu_out, stall, rd_data, hi, lo, busy, done).
module hilo_unit
    import mips_pkg::*;
#(
    parameter int MULT_LATENCY = MULT_LATENCY_DEF,
    parameter int CNT_W        = 6
)(
    input  logic   clk,
    input  logic   reset,
    hilo_if.slave  bus
);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;
    logic             is_idle;
    logic             is_busy;
    logic             accept;
    logic             capture;
    logic             mt_ok;
    logic             hi_we;
    logic             lo_we;
    logic [WORD_W-1:0] hi_wdata;
    logic [WORD_W-1:0] lo_wdata;
    logic [WORD_W-1:0] hi_s;
    logic [WORD_W-1:0] lo_s;

    assign is_idle = (state_q == HILO_IDLE);
    assign is_busy = (state_q == HILO_BUSY);

    // Gated by reset so Multu never fires while the unit is held in reset.
    assign accept = bus.mult_start & is_idle & ~bus.flush & reset;

    // FSM and latency counter; the counter only reloads from IDLE and sits at 0 there
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            HILO_IDLE: begin
                if (accept) begin
                    state_d = HILO_BUSY;
                    cnt_d   = CNT_W'(MULT_LATENCY - 1);
                end else begin
                    state_d = HILO_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            HILO_BUSY: begin
                if (bus.flush) begin
                    state_d = HILO_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = HILO_IDLE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = HILO_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign done_d = capture;

    // A MULTU in the same cycle takes precedence over MTHI/MTLO.
    assign mt_ok    = is_idle & ~bus.flush & ~bus.mult_start;
    assign hi_we    = capture | (mt_ok & bus.mthi);
    assign lo_we    = capture | (mt_ok & bus.mtlo);
    assign hi_wdata = capture ? bus.mult_product[DWORD_W-1:WORD_W] : bus.wr_data;
    assign lo_wdata = capture ? bus.mult_product[WORD_W-1:0]       : bus.wr_data;

    // FSM, counter and done flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HILO_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    hilo_regs u_regs (
        .clk      (clk),
        .reset    (reset),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .hi       (hi_s),
        .lo       (lo_s)
    );

    // MFHI/MFLO read mux; register contents only, MFHI has priority
    always_comb begin
        if (bus.mfhi) begin
            bus.rd_data = hi_s;
        end else if (bus.mflo) begin
            bus.rd_data = lo_s;
        end else begin
            bus.rd_data = {WORD_W{1'b0}};
        end
    end

    assign bus.multu_out = accept;
    assign bus.stall     = is_busy & (bus.mult_start | bus.mfhi | bus.mflo |
                                      bus.mthi | bus.mtlo) & ~bus.flush;
    assign bus.hi        = hi_s;
    assign bus.lo        = lo_s;
    assign bus.busy      = is_busy;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_if bus ();

    hilo_unit #(.MULT_LATENCY(34), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { string name; logic [31:0] hi; logic [31:0] lo; } mexp_t;
    typedef struct { string name; logic [31:0] val; } rexp_t;
    mexp_t mq[$];
    rexp_t rq[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: done pulses pop multiply results, unstalled reads pop read results
    always @(negedge clk) begin
        mexp_t me;
        rexp_t re;
        if (reset === 1'b1) begin
            if (bus.done === 1'b1) begin
                if (mq.size() == 0) begin
                    check("done_without_mult", bus.done, 64'd0);
                end else begin
                    me = mq.pop_front();
                    check({me.name, "_hi"}, bus.hi, me.hi);
                    check({me.name, "_lo"}, bus.lo, me.lo);
                end
            end
            if (((bus.mfhi | bus.mflo) === 1'b1) && (bus.stall === 1'b0)) begin
                if (rq.size() == 0) begin
                    check("read_without_expect", rq.size(), 64'd1);
                end else begin
                    re = rq.pop_front();
                    check(re.name, bus.rd_data, re.val);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mult_start = 1'b0;
        bus.flush      = 1'b0;
        bus.mfhi       = 1'b0;
        bus.mflo       = 1'b0;
        bus.mthi       = 1'b0;
        bus.mtlo       = 1'b0;
        bus.wr_data    = 32'h0;
    endtask

    // Present a MULTU for one accepting cycle; leaves caller just after the accepting edge
    task automatic do_issue(input logic [63:0] p, input bit push, input string name,
                            input logic [31:0] ehi, input logic [31:0] elo);
        mexp_t e;
        bus.mult_start   = 1'b1;
        bus.mult_product = p;
        @(negedge clk);
        check({name, "_multu_out"}, bus.multu_out, 64'd1);
        check({name, "_no_stall"}, bus.stall, 64'd0);
        if (push) begin
            e.name = name; e.hi = ehi; e.lo = elo;
            mq.push_back(e);
        end
        cyc();
        bus.mult_start = 1'b0;
    endtask

    // Count negedges with busy high, bounded
    task automatic wait_busy(output int n);
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ns, nm;
        rexp_t r;
        mexp_t e;
        idle_inputs();
        bus.mult_product = 64'h0;
        reset = 1'b1;
        #2;
        reset = 1'b0;

        // 1. reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.mult_start   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.flush        = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.mfhi         = 1'($urandom_range(0, 1));
            bus.mflo         = 1'($urandom_range(0, 1));
            bus.mthi         = 1'b1;
            bus.mtlo         = 1'b1;
            bus.wr_data      = $urandom;
            bus.mult_product = {$urandom, $urandom};
            @(negedge clk);
            check("rst_hi", bus.hi, 64'd0);
            check("rst_lo", bus.lo, 64'd0);
            check("rst_stall", bus.stall, 64'd0);
            check("rst_busy", bus.busy, 64'd0);
            check("rst_done", bus.done, 64'd0);
            check("rst_multu_out", bus.multu_out, 64'd0);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_hi", bus.hi, 64'd0);
        check("post_rst_lo", bus.lo, 64'd0);
        check("post_rst_busy", bus.busy, 64'd0);
        check("post_rst_done", bus.done, 64'd0);

        // 2. FFFFFFFF * 2
        cyc();
        do_issue(64'h0000_0001_FFFF_FFFE, 1'b1, "t2", 32'h0000_0001, 32'hFFFF_FFFE);
        wait_busy(n);
        check("t2_busy_cycles", n, 64'd34);
        check("t2_done_pulse", bus.done, 64'd1);
        cyc();
        @(negedge clk);
        check("t2_done_single", bus.done, 64'd0);

        // 3. MFLO three cycles after MULTU (7*6)
        cyc();
        do_issue(64'd42, 1'b1, "t3", 32'h0, 32'd42);
        cyc();
        cyc();
        bus.mflo = 1'b1;
        r.name = "t3_mflo_rd"; r.val = 32'd42;
        rq.push_back(r);
        ns = 0;
        @(negedge clk);
        while (bus.stall === 1'b1 && ns < 100) begin
            ns++;
            @(negedge clk);
        end
        check("t3_stall_cycles", ns, 64'd32);
        check("t3_busy_after", bus.busy, 64'd0);
        cyc();
        bus.mflo = 1'b0;

        // 4. flush at cnt==0 keeps previous HI/LO
        bus.mthi    = 1'b1;
        bus.wr_data = 32'hA5A5_A5A5;
        cyc();
        idle_inputs();
        @(negedge clk);
        check("t4_mthi_hi", bus.hi, 64'hA5A5_A5A5);
        check("t4_mthi_lo_kept", bus.lo, 64'd42);
        cyc();
        do_issue(64'hDEAD_BEEF_0BAD_F00D, 1'b0, "t4", 32'h0, 32'h0);
        repeat (33) cyc();
        bus.flush      = 1'b1;
        bus.mthi       = 1'b1;
        bus.mult_start = 1'b1;
        bus.wr_data    = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t4_busy_at_flush", bus.busy, 64'd1);
        check("t4_flush_no_stall", bus.stall, 64'd0);
        check("t4_flush_no_multu", bus.multu_out, 64'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        check("t4_idle_after_flush", bus.busy, 64'd0);
        check("t4_no_done", bus.done, 64'd0);
        check("t4_hi_kept", bus.hi, 64'hA5A5_A5A5);
        check("t4_lo_kept", bus.lo, 64'd42);
        cyc();
        @(negedge clk);
        check("t4_no_done_late", bus.done, 64'd0);

        // 5. MTHI+MTLO together, then MFHI+MFLO priority
        cyc();
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'h1234_5678;
        cyc();
        idle_inputs();
        @(negedge clk);
        check("t5_hi", bus.hi, 64'h1234_5678);
        check("t5_lo", bus.lo, 64'h1234_5678);
        cyc();
        bus.mtlo    = 1'b1;
        bus.wr_data = 32'h0BAD_F00D;
        cyc();
        idle_inputs();
        @(negedge clk);
        check("t5_mtlo_only_lo", bus.lo, 64'h0BAD_F00D);
        check("t5_mtlo_only_hi", bus.hi, 64'h1234_5678);
        cyc();
        bus.mfhi = 1'b1;
        bus.mflo = 1'b1;
        r.name = "t5_mfhi_prio"; r.val = 32'h1234_5678;
        rq.push_back(r);
        cyc();
        bus.mfhi = 1'b0;
        r.name = "t5_mflo_rd"; r.val = 32'h0BAD_F00D;
        rq.push_back(r);
        cyc();
        bus.mflo = 1'b0;
        @(negedge clk);
        check("t5_rd_zero", bus.rd_data, 64'd0);

        // 6. second MULTU while busy (3*5, then new window)
        cyc();
        do_issue(64'd15, 1'b1, "t6a", 32'h0, 32'd15);
        repeat (4) cyc();
        bus.mult_start = 1'b1;
        n = 0; ns = 0; nm = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (bus.stall === 1'b1) ns++;
            if (bus.multu_out === 1'b1) nm++;
            @(negedge clk);
        end
        check("t6_busy_left", n, 64'd30);
        check("t6_stall_cycles", ns, 64'd30);
        check("t6_no_fwd_multu", nm, 64'd0);
        check("t6_accept_multu", bus.multu_out, 64'd1);
        check("t6_accept_no_stall", bus.stall, 64'd0);
        check("t6_first_done", bus.done, 64'd1);
        e.name = "t6b"; e.hi = 32'h0000_0002; e.lo = 32'h0000_0003;
        mq.push_back(e);
        cyc();
        bus.mult_start   = 1'b0;
        bus.mult_product = 64'h0000_0002_0000_0003;
        wait_busy(n);
        check("t6_second_busy", n, 64'd34);
        cyc();
        @(negedge clk);

        check("mult_queue_drained", mq.size(), 64'd0);
        check("read_queue_drained", rq.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
